// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller: FSM states,
// instruction fields, ALU32Bit control codes and datapath mux selects.
package mc_pkg;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_EXEC_R = 4'd2,
        ST_EXEC_I = 4'd3,
        ST_ADDR   = 4'd4,
        ST_MEM_RD = 4'd5,
        ST_MEM_WR = 4'd6,
        ST_WB_R   = 4'd7,
        ST_WB_I   = 4'd8,
        ST_WB_MEM = 4'd9,
        ST_BRANCH = 4'd10,
        ST_JUMP   = 4'd11,
        ST_TRAP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic       reg_b;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic [1:0] pc_source;
        logic       retire;
        logic       trap;
    } ctrl_t;

    function automatic logic is_i_alu(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_SLTI);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational opcode/funct decoder: picks the ALU32Bit code, the shamt
// select for shifts, and flags encodings the controller cannot execute.
module alu_decoder
    import mc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       reg_b,
    output logic       valid
);

    always_comb begin
        alu_op = ALU_ADD;
        reg_b  = 1'b0;
        valid  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                valid = 1'b1;
                case (funct)
                    FN_ADD: alu_op = ALU_ADD;
                    FN_SUB: alu_op = ALU_SUB;
                    FN_AND: alu_op = ALU_AND;
                    FN_OR:  alu_op = ALU_OR;
                    FN_SLT: alu_op = ALU_SLT;
                    FN_SLL: begin
                        alu_op = ALU_SLL;
                        reg_b  = 1'b1;
                    end
                    FN_SRL: begin
                        alu_op = ALU_SRL;
                        reg_b  = 1'b1;
                    end
                    default: valid = 1'b0;
                endcase
            end
            OP_ADDI: begin
                valid  = 1'b1;
                alu_op = ALU_ADD;
            end
            OP_ANDI: begin
                valid  = 1'b1;
                alu_op = ALU_AND;
            end
            OP_ORI: begin
                valid  = 1'b1;
                alu_op = ALU_OR;
            end
            OP_SLTI: begin
                valid  = 1'b1;
                alu_op = ALU_SLT;
            end
            // Memory and jump instructions only use the ALU for address math.
            OP_LW, OP_SW, OP_J: valid = 1'b1;
            OP_BEQ, OP_BNE: begin
                valid  = 1'b1;
                alu_op = ALU_SUB;
            end
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle control FSM for the MIPS-subset datapath: sequences fetch, decode,
// execute, memory and writeback over the shared ALU and single memory port.
module multicycle_controller
    import mc_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic       RegB,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       Retire,
    output logic       Trap,
    output logic [3:0] State
);

    state_t     state;
    ctrl_t      ctrl;
    logic [3:0] dec_alu_op;
    logic       dec_reg_b;
    logic       dec_valid;

    alu_decoder u_alu_decoder (
        .opcode (Opcode),
        .funct  (Funct),
        .alu_op (dec_alu_op),
        .reg_b  (dec_reg_b),
        .valid  (dec_valid)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= ST_FETCH;
        end else begin
            case (state)
                ST_FETCH:  if (MemReady) state <= ST_DECODE;
                ST_DECODE: begin
                    if (!dec_valid)                        state <= ST_TRAP;
                    else if (Opcode == OP_RTYPE)           state <= ST_EXEC_R;
                    else if (Opcode == OP_LW || Opcode == OP_SW)
                                                           state <= ST_ADDR;
                    else if (Opcode == OP_BEQ || Opcode == OP_BNE)
                                                           state <= ST_BRANCH;
                    else if (Opcode == OP_J)               state <= ST_JUMP;
                    else if (is_i_alu(Opcode))             state <= ST_EXEC_I;
                    else                                   state <= ST_TRAP;
                end
                ST_EXEC_R: state <= ST_WB_R;
                ST_EXEC_I: state <= ST_WB_I;
                ST_ADDR:   state <= (Opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
                ST_MEM_RD: if (MemReady) state <= ST_WB_MEM;
                ST_MEM_WR: if (MemReady) state <= ST_FETCH;
                ST_WB_R, ST_WB_I, ST_WB_MEM, ST_BRANCH, ST_JUMP:
                           state <= ST_FETCH;
                ST_TRAP:   state <= ST_TRAP;
                default:   state <= ST_TRAP;
            endcase
        end
    end

    // Outputs follow the state register; MemReady and Zero gate strobes in the
    // same cycle, and Reset suppresses everything so no partial write escapes.
    always_comb begin
        ctrl = '0;
        if (!Reset) begin
            case (state)
                ST_FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.alu_src_b = SRCB_FOUR;
                    ctrl.alu_op    = ALU_ADD;
                    ctrl.pc_source = PCSRC_ALU;
                    ctrl.ir_write  = MemReady;
                    ctrl.pc_write  = MemReady;
                end
                ST_DECODE: begin
                    ctrl.alu_src_b = SRCB_IMM_SH2;
                    ctrl.alu_op    = ALU_ADD;
                end
                ST_EXEC_R: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_REG;
                    ctrl.alu_op    = dec_alu_op;
                    ctrl.reg_b     = dec_reg_b;
                end
                ST_EXEC_I: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = dec_alu_op;
                end
                ST_ADDR: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = ALU_ADD;
                end
                ST_MEM_RD: begin
                    ctrl.iord     = 1'b1;
                    ctrl.mem_read = 1'b1;
                end
                ST_MEM_WR: begin
                    ctrl.iord      = 1'b1;
                    ctrl.mem_write = 1'b1;
                    ctrl.retire    = MemReady;
                end
                ST_WB_R: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = 1'b1;
                    ctrl.retire    = 1'b1;
                end
                ST_WB_I: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.retire    = 1'b1;
                end
                ST_WB_MEM: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                    ctrl.retire     = 1'b1;
                end
                ST_BRANCH: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_REG;
                    ctrl.alu_op    = ALU_SUB;
                    ctrl.pc_source = PCSRC_ALUOUT;
                    ctrl.pc_write  = ((Opcode == OP_BEQ) && Zero) ||
                                     ((Opcode == OP_BNE) && !Zero);
                    ctrl.retire    = 1'b1;
                end
                ST_JUMP: begin
                    ctrl.pc_source = PCSRC_JUMP;
                    ctrl.pc_write  = 1'b1;
                    ctrl.retire    = 1'b1;
                end
                ST_TRAP: ctrl.trap = 1'b1;
                default: ctrl = '0;
            endcase
        end
    end

    assign PCWrite  = ctrl.pc_write;
    assign IRWrite  = ctrl.ir_write;
    assign RegWrite = ctrl.reg_write;
    assign MemRead  = ctrl.mem_read;
    assign MemWrite = ctrl.mem_write;
    assign IorD     = ctrl.iord;
    assign RegDst   = ctrl.reg_dst;
    assign MemtoReg = ctrl.mem_to_reg;
    assign ALUSrcA  = ctrl.alu_src_a;
    assign RegB     = ctrl.reg_b;
    assign ALUSrcB  = ctrl.alu_src_b;
    assign ALUOp    = ctrl.alu_op;
    assign PCSource = ctrl.pc_source;
    assign Retire   = ctrl.retire;
    assign Trap     = ctrl.trap;
    assign State    = state;

endmodule
